// File: rtl/store_buf_pkg.sv
// rtl/store_buf_pkg.sv - shared widths, entry type and address/index helpers for store_buffer
package store_buf_pkg;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 8;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return addr[IDX_W+1:2];
    endfunction

    function automatic logic [31:0] idx_addr(input logic [IDX_W-1:0] idx);
        return {{(30-IDX_W){1'b0}}, idx, 2'b00};
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - CPU-side and memory-side signals of the store buffer
interface store_buffer_if;
    import store_buf_pkg::*;

    logic              cpu_read;
    logic              cpu_write;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              stall;
    logic              flush_req;
    logic              empty;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, flush_req, mem_rdata,
        input  cpu_rdata, stall, empty, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, flush_req, mem_rdata,
        output cpu_rdata, stall, empty, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/sb_match.sv
// rtl/sb_match.sv - youngest-match search over the valid queued stores (head..head+count-1)
module sb_match
    import store_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  sb_entry_t         ent [DEPTH],
    input  logic [PW-1:0]     head,
    input  logic [PW:0]       count,
    input  logic [IDX_W-1:0]  idx,
    output logic              hit,
    output logic [PW-1:0]     hit_ptr,
    output logic [DATA_W-1:0] hit_data
);

    logic [PW-1:0] p;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit      = 1'b0;
        hit_ptr  = head;
        hit_data = '0;
        p        = head;
        for (int k = 0; k < DEPTH; k++) begin
            p = head + PW'(k);
            if (((PW+1)'(k) < count) && (ent[p].idx == idx)) begin
                hit      = 1'b1;
                hit_ptr  = p;
                hit_data = ent[p].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer with load forwarding; STORE_BUF_COALESCE_EN merges same-index stores
module store_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t         ent_q [DEPTH];
    logic [PW-1:0]     head_q, tail_q, hit_ptr, wr_ptr;
    logic [PW:0]       count_q;
    logic              flush_block_q, flush_block, full, is_empty;
    logic              hit, push, coalesce, drain, store_ok;
    logic [IDX_W-1:0]  cpu_idx;
    logic [DATA_W-1:0] hit_data;

    assign cpu_idx     = word_idx(bus.cpu_addr);
    assign full        = (count_q == (PW+1)'(DEPTH));
    assign is_empty    = (count_q == '0);
    // Sticky once raised while entries remain; drops as soon as the queue is empty.
    assign flush_block = (flush_block_q || bus.flush_req) && !is_empty;
    assign store_ok    = bus.cpu_write && !bus.cpu_read && !flush_block;

    sb_match #(.DEPTH(DEPTH)) u_match (
        .ent      (ent_q),
        .head     (head_q),
        .count    (count_q),
        .idx      (cpu_idx),
        .hit      (hit),
        .hit_ptr  (hit_ptr),
        .hit_data (hit_data)
    );

`ifdef STORE_BUF_COALESCE_EN
    assign coalesce  = store_ok && hit;
    assign push      = store_ok && !hit && !full;
    assign bus.stall = bus.cpu_write && (bus.cpu_read || flush_block || (full && !hit));
`else
    assign coalesce  = 1'b0;
    assign push      = store_ok && !full;
    assign bus.stall = bus.cpu_write && (bus.cpu_read || full || flush_block);
`endif

    // An accepted store (push or merge) owns the port cycle even though it does not use it.
    assign drain     = !bus.cpu_read && !push && !coalesce && !is_empty;
    assign wr_ptr    = coalesce ? hit_ptr : tail_q;
    assign bus.empty = is_empty;

    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.cpu_rdata = '0;
        if (bus.cpu_read) begin
            bus.mem_read  = 1'b1;
            bus.mem_addr  = idx_addr(cpu_idx);
            bus.cpu_rdata = hit ? hit_data : bus.mem_rdata;
        end else if (drain) begin
            bus.mem_write = 1'b1;
            bus.mem_addr  = idx_addr(ent_q[head_q].idx);
            bus.mem_wdata = ent_q[head_q].data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            flush_block_q <= 1'b0;
        end else begin
            flush_block_q <= flush_block;
            if (push) begin
                tail_q  <= tail_q + PW'(1);
                count_q <= count_q + (PW+1)'(1);
            end
            if (drain) begin
                head_q  <= head_q + PW'(1);
                count_q <= count_q - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push || coalesce) begin
            ent_q[wr_ptr] <= '{idx: cpu_idx, data: bus.cpu_wdata};
        end
    end

endmodule
